// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite line scheduler slice.
//   CORDW_DEF     : coordinate width stored in the object table
//   SLOT_NONE     : object index reported by a slot that received no object
//   sched_state_e : scheduler FSM states
//   obj_entry_t   : one object table entry {active, x, y}
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int CORDW_DEF = 16;
    localparam int SLOT_NONE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                        active;
        logic signed [CORDW_DEF-1:0] x;
        logic signed [CORDW_DEF-1:0] y;
    } obj_entry_t;

endpackage

// File: rtl/obj_table.sv
// ---------------------------------------------------------------------------
// obj_table
// Double-buffered object table. Game logic writes only the shadow copy; a
// commit copies every shadow entry into the live copy in a single cycle.
// A write and a commit in the same cycle copy the freshly written data.
// The scheduler reads the live copy combinationally by index.
// Ports:
//   i_clk_25, i_rst_n : pixel clock, async active-low reset (clears both copies)
//   wr_en, wr_idx     : shadow write strobe and target index
//   wr_entry          : entry written to the shadow copy
//   commit            : copy shadow (including this cycle's write) to live
//   rd_idx, rd_entry  : combinational live-table read
// ---------------------------------------------------------------------------
module obj_table
    import sprite_pkg::*;
#(
    parameter int N_OBJ = 16,
    parameter int IDXW  = $clog2(N_OBJ)
) (
    input  logic            i_clk_25,
    input  logic            i_rst_n,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  obj_entry_t      wr_entry,
    input  logic            commit,
    input  logic [IDXW-1:0] rd_idx,
    output obj_entry_t      rd_entry
);

    obj_entry_t shadow_r     [N_OBJ];
    obj_entry_t live_r       [N_OBJ];
    obj_entry_t shadow_nxt_s [N_OBJ];

    // Shadow contents after this cycle's write, so a same-cycle commit sees it.
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            if (wr_en && (wr_idx == IDXW'(i))) begin
                shadow_nxt_s[i] = wr_entry;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Shadow and live storage; live only moves on commit.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_r[i] <= '0;
                live_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
                if (commit) begin
                    live_r[i] <= shadow_nxt_s[i];
                end
            end
        end
    end

    // Live-table read port for the scanner.
    always_comb begin
        rd_entry = live_r[rd_idx];
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_line_scheduler
// Shares N_SLOT sprite render engines among N_OBJ objects, once per scanline.
// A line pulse in IDLE starts a scan that visits one object per cycle in
// ascending index order; visible objects fill slots 0,1,2.. and, one cycle
// after the last object, the used slots receive a one-cycle start pulse with
// the object's x, source row and index.
// Ports:
//   i_clk_25, i_rst_n        : pixel clock, async active-low reset
//   sy                       : current screen line (signed)
//   line                     : one-cycle pulse at the start of each line
//   wr_en/wr_idx/wr_active/
//   wr_x/wr_y                : shadow object table write port
//   commit                   : copy shadow table to live (held while busy)
//   slot_start               : per-slot start pulse
//   slot_x/slot_row/slot_obj : per-slot x, source row and owning object
//   busy                     : scan or issue in progress
//   overflow                 : sticky, too many objects on a line
//   late_err                 : sticky, line pulse arrived while busy
// ---------------------------------------------------------------------------
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int N_OBJ   = 16,
    parameter int N_SLOT  = 4,
    parameter int HEIGHT  = 128,
    parameter int SCALE_Y = 1,
    parameter int CORDW   = CORDW_DEF,
    parameter int IDXW    = $clog2(N_OBJ)
) (
    input  logic                              i_clk_25,
    input  logic                              i_rst_n,
    input  logic signed [CORDW-1:0]           sy,
    input  logic                              line,
    input  logic                              wr_en,
    input  logic [IDXW-1:0]                   wr_idx,
    input  logic                              wr_active,
    input  logic signed [CORDW-1:0]           wr_x,
    input  logic signed [CORDW-1:0]           wr_y,
    input  logic                              commit,
    output logic [N_SLOT-1:0]                 slot_start,
    output logic [N_SLOT*CORDW-1:0]           slot_x,
    output logic [N_SLOT*$clog2(HEIGHT)-1:0]  slot_row,
    output logic [N_SLOT*IDXW-1:0]            slot_obj,
    output logic                              busy,
    output logic                              overflow,
    output logic                              late_err
);

    localparam int ROWW      = $clog2(HEIGHT);
    localparam int CNTW      = $clog2(N_SLOT + 1);
    localparam int ROW_SHIFT = $clog2(SCALE_Y);
    localparam logic [CORDW-1:0] SPAN     = CORDW'(HEIGHT * SCALE_Y);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N_OBJ - 1);

    sched_state_e            state_r;
    logic [IDXW-1:0]         idx_r;
    logic [CNTW-1:0]         cnt_r;
    logic                    commit_pend_r;
    logic [N_SLOT-1:0]       pend_mask_r;
    logic signed [CORDW-1:0] pend_x_r   [N_SLOT];
    logic [ROWW-1:0]         pend_row_r [N_SLOT];
    logic [IDXW-1:0]         pend_obj_r [N_SLOT];

    obj_entry_t              wr_entry_s;
    obj_entry_t              rd_entry_s;
    logic                    commit_now_s;
    logic [CORDW:0]          diff_s;
    logic                    visible_s;
    logic                    take_s;
    logic                    drop_s;
    logic [ROWW-1:0]         row_s;
    logic [CNTW-1:0]         cnt_nxt_s;
    logic [N_SLOT-1:0]       nxt_mask_s;
    logic signed [CORDW-1:0] nxt_x_s   [N_SLOT];
    logic [ROWW-1:0]         nxt_row_s [N_SLOT];
    logic [IDXW-1:0]         nxt_obj_s [N_SLOT];

    // Commits only reach the live table while idle, keeping it stable mid-scan.
    always_comb begin
        wr_entry_s   = '{active: wr_active, x: wr_x, y: wr_y};
        commit_now_s = (state_r == IDLE) && (commit || commit_pend_r);
    end

    obj_table #(
        .N_OBJ (N_OBJ),
        .IDXW  (IDXW)
    ) u_obj_table (
        .i_clk_25 (i_clk_25),
        .i_rst_n  (i_rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_entry (wr_entry_s),
        .commit   (commit_now_s),
        .rd_idx   (idx_r),
        .rd_entry (rd_entry_s)
    );

    // Visibility test: sy-y in one extra bit so the sign is exact, no wrap.
    always_comb begin
        diff_s    = {sy[CORDW-1], sy} - {rd_entry_s.y[CORDW-1], rd_entry_s.y};
        visible_s = (state_r == SCAN) && rd_entry_s.active &&
                    (diff_s[CORDW] == 1'b0) && (diff_s[CORDW-1:0] < SPAN);
        take_s    = visible_s && (cnt_r < CNTW'(N_SLOT));
        drop_s    = visible_s && (cnt_r >= CNTW'(N_SLOT));
        row_s     = ROWW'(diff_s[CORDW-1:0] >> ROW_SHIFT);
        if (take_s) begin
            cnt_nxt_s = cnt_r + CNTW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Slot allocator: the object being scanned lands in the next free slot.
    always_comb begin
        for (int s = 0; s < N_SLOT; s++) begin
            if (take_s && (cnt_r == CNTW'(s))) begin
                nxt_mask_s[s] = 1'b1;
                nxt_x_s[s]    = rd_entry_s.x;
                nxt_row_s[s]  = row_s;
                nxt_obj_s[s]  = idx_r;
            end else begin
                nxt_mask_s[s] = pend_mask_r[s];
                nxt_x_s[s]    = pend_x_r[s];
                nxt_row_s[s]  = pend_row_r[s];
                nxt_obj_s[s]  = pend_obj_r[s];
            end
        end
    end

    // Scheduler FSM with scan counter, allocation state, sticky flags and outputs.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            cnt_r         <= '0;
            commit_pend_r <= 1'b0;
            pend_mask_r   <= '0;
            for (int s = 0; s < N_SLOT; s++) begin
                pend_x_r[s]   <= '0;
                pend_row_r[s] <= '0;
                pend_obj_r[s] <= '0;
            end
            slot_start    <= '0;
            slot_x        <= '0;
            slot_row      <= '0;
            slot_obj      <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            late_err      <= 1'b0;
        end else begin
            slot_start <= '0;

            if (state_r == IDLE) begin
                commit_pend_r <= 1'b0;
            end else if (commit) begin
                commit_pend_r <= 1'b1;
            end

            // A line pulse outside IDLE is ignored; the scan carries on.
            if (line && (state_r != IDLE)) begin
                late_err <= 1'b1;
            end

            if (drop_s) begin
                overflow <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (line) begin
                        state_r     <= SCAN;
                        busy        <= 1'b1;
                        idx_r       <= '0;
                        cnt_r       <= '0;
                        pend_mask_r <= '0;
                        for (int s = 0; s < N_SLOT; s++) begin
                            pend_x_r[s]   <= '0;
                            pend_row_r[s] <= '0;
                            pend_obj_r[s] <= IDXW'(SLOT_NONE);
                        end
                        // Line 0 marks a new frame: sticky flags restart.
                        if (sy == '0) begin
                            overflow <= 1'b0;
                            late_err <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    cnt_r       <= cnt_nxt_s;
                    idx_r       <= idx_r + IDXW'(1);
                    pend_mask_r <= nxt_mask_s;
                    for (int s = 0; s < N_SLOT; s++) begin
                        pend_x_r[s]   <= nxt_x_s[s];
                        pend_row_r[s] <= nxt_row_s[s];
                        pend_obj_r[s] <= nxt_obj_s[s];
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r    <= ISSUE;
                        slot_start <= nxt_mask_s;
                        for (int s = 0; s < N_SLOT; s++) begin
                            slot_x[s*CORDW +: CORDW] <= nxt_x_s[s];
                            slot_row[s*ROWW +: ROWW] <= nxt_row_s[s];
                            slot_obj[s*IDXW +: IDXW] <= nxt_obj_s[s];
                        end
                    end
                end
                ISSUE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
